// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x-oversampled UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined)
module uart_rx_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I_baudrate_rx_clk,
    input  logic       I_rx,
    output logic [7:0] O_rx_data,
    output logic       O_rx_valid,
    output logic       O_rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       O_rx_parity_err,
`endif
    output logic       O_rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic       parity_bit_q, parity_bit_d;
    logic       parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_meta_d    = I_rx;
        rx_s_d       = rx_meta_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Edge detection is not gated by the tick so back-to-back frames lose no time
                if (!rx_s_q) begin
                    tick_cnt_d = 4'd0;
                    state_d    = START;
                end
            end
            START: begin
                if (I_baudrate_rx_clk) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd7) begin
                        if (!rx_s_q) begin
                            tick_cnt_d = 4'd0;
                            bit_cnt_d  = 3'd0;
                            state_d    = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (I_baudrate_rx_clk) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (I_baudrate_rx_clk) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        parity_bit_d = rx_s_q;
                        state_d      = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (I_baudrate_rx_clk) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d  = 4'd0;
                        data_d      = shift_q;
                        valid_d     = 1'b1;
                        frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
                        state_d     = rx_s_q ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start edge counts
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign O_rx_data      = data_q;
    assign O_rx_valid     = valid_q;
    assign O_rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign O_rx_parity_err = parity_err_q;
`endif
    assign O_rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed-vector bench for uart_rx_core
module tb_uart_rx_core;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] got_data[$];
    logic       got_ferr[$];
    logic       got_perr[$];
    int         ferr_pulses = 0;

    uart_rx_core dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .I_baudrate_rx_clk (tick),
        .I_rx              (rx),
        .O_rx_data         (rx_data),
        .O_rx_valid        (rx_valid),
        .O_rx_frame_err    (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .O_rx_parity_err   (rx_parity_err),
`endif
        .O_rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_frame_err) ferr_pulses++;
        if (rx_valid) begin
            got_data.push_back(rx_data);
            got_ferr.push_back(rx_frame_err);
`ifdef UART_RX_PARITY_EN
            got_perr.push_back(rx_parity_err);
`else
            got_perr.push_back(1'b0);
`endif
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_data", rx_data, 8'h00);
        check_val("rst_valid", rx_valid, 1'b0);
        check_val("rst_ferr", rx_frame_err, 1'b0);
        check_val("rst_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        idle(40);

        // 0xA5, 8N1 (even parity bit 0 when parity is built in)
        base = got_data.size();
        send_bit(1'b0);
        check_val("a5_busy_mid", rx_busy, 1'b1);
        send_data(8'hA5);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b1);
        idle(100);
        check_val("a5_count", got_data.size() - base, 1);
        check_val("a5_data", got_data[base], 8'hA5);
        check_val("a5_ferr", got_ferr[base], 1'b0);
        check_val("a5_busy_after", rx_busy, 1'b0);
        check_val("a5_hold", rx_data, 8'hA5);

        // false start: 3 ticks low
        base = got_data.size();
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        check_val("fs_busy_start", rx_busy, 1'b1);
        repeat (8 * TICK_DIV - 3 * TICK_DIV + 6) @(negedge clk);
        check_val("fs_idle_by_tick8", rx_busy, 1'b0);
        idle(200);
        check_val("fs_no_valid", got_data.size() - base, 0);

        // 0x3C with low stop bit, then 40 ticks low
        base = got_data.size();
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40 * TICK_DIV) @(negedge clk);
        check_val("brk_count", got_data.size() - base, 1);
        check_val("brk_data", got_data[base], 8'h3C);
        check_val("brk_ferr", got_ferr[base], 1'b1);
        check_val("brk_ferr_pulses", ferr_pulses, 1);
        check_val("brk_busy", rx_busy, 1'b1);
        idle(100);
        check_val("brk_busy_release", rx_busy, 1'b0);
        check_val("brk_no_second", got_data.size() - base, 1);

        // back-to-back 0x00 and 0xFF
        base = got_data.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(100);
        check_val("b2b_count", got_data.size() - base, 2);
        check_val("b2b_data0", got_data[base], 8'h00);
        check_val("b2b_data1", got_data[base+1], 8'hFF);
        check_val("b2b_ferr0", got_ferr[base], 1'b0);
        check_val("b2b_ferr1", got_ferr[base+1], 1'b0);

`ifdef UART_RX_PARITY_EN
        base = got_data.size();
        send_frame(8'h01, 1'b0, 1'b1);
        idle(50);
        send_frame(8'h01, 1'b1, 1'b1);
        idle(100);
        check_val("par_count", got_data.size() - base, 2);
        check_val("par_bad", got_perr[base], 1'b1);
        check_val("par_good", got_perr[base+1], 1'b0);
`endif

        // reset during bit 4 of a frame
        base = got_data.size();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check_val("mrst_data", rx_data, 8'h00);
        check_val("mrst_valid", rx_valid, 1'b0);
        check_val("mrst_ferr", rx_frame_err, 1'b0);
        check_val("mrst_busy", rx_busy, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(12 * BIT_CLKS);
        check_val("mrst_no_pulse", got_data.size() - base, 0);
        check_val("mrst_busy_after", rx_busy, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(100);
        check_val("mrst_next_count", got_data.size() - base, 1);
        check_val("mrst_next_data", got_data[base], 8'h5A);
        check_val("mrst_next_ferr", got_ferr[base], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic is on the rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port I_baudrate_rx_clk, input, 1, 16x-oversample tick from the baud generator, one clk cycle wide.
REQ-004 SHALL have port I_rx, input, 1, asynchronous serial line; idle level is high.
REQ-005 SHALL have port O_rx_data, output, 8, last received byte.
REQ-006 SHALL have port O_rx_valid, output, 1, one-clk pulse when O_rx_data updates.
REQ-007 SHALL have port O_rx_frame_err, output, 1, one-clk pulse, coincident with O_rx_valid, when the stop bit is sampled low.
REQ-008 SHALL have port O_rx_busy, output, 1, high in every state except IDLE.

Function
REQ-009 SHALL pass I_rx through a 2-flop synchronizer; all internal decisions use the synchronized value rx_s.
REQ-010 SHALL advance the tick counter (0-15) and the bit counter (0-7) only in cycles where I_baudrate_rx_clk=1.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-012 IDLE: on rx_s=0, SHALL clear the tick counter and enter START.
REQ-013 START: at tick count 7 (mid-bit), if rx_s=0 SHALL clear the tick counter and enter DATA; if rx_s=1 SHALL treat it as a false start and return to IDLE with no output pulse.
REQ-014 DATA: at each tick count 15 SHALL shift rx_s into the shift register, LSB first; after the 8th bit SHALL enter PARITY or STOP.
REQ-015 STOP: at tick count 15 SHALL sample rx_s, load O_rx_data, and pulse O_rx_valid in the next clk cycle.
REQ-016 STOP: if the stop sample is 0, SHALL also pulse O_rx_frame_err and enter BREAK; otherwise SHALL enter IDLE.
REQ-017 BREAK: SHALL remain until rx_s=1, then enter IDLE; no new frame is detected while the line stays low.
REQ-018 O_rx_data SHALL hold its value between O_rx_valid pulses; a frame-error byte is still delivered.
REQ-019 A start edge arriving in the same clk cycle that STOP returns to IDLE SHALL be detected in the next clk cycle; back-to-back frames with no idle gap SHALL be received.
REQ-020 If I_baudrate_rx_clk stays low, SHALL hold its state and counters indefinitely.

Reset
REQ-021 On rst_n=0, state SHALL go to IDLE immediately, asynchronously and at any point mid-frame.
REQ-022 Reset values SHALL be: O_rx_data=8'h00, O_rx_valid=0, O_rx_frame_err=0, O_rx_busy=0, counters=0, and both synchronizer flops=1.
REQ-023 A partially received frame SHALL be discarded on reset with no output pulse.

Configuration
REQ-024 Macro UART_RX_PARITY_EN SHALL select the frame format.
REQ-025 With UART_RX_PARITY_EN defined: format is 8E1; state PARITY samples at tick count 15; port O_rx_parity_err (output, 1) pulses with O_rx_valid when the XOR of the data and parity bits is 1.
REQ-026 With UART_RX_PARITY_EN undefined: format is 8N1; the PARITY state and the O_rx_parity_err port are absent.

Verification
REQ-027 Send 0xA5 in 8N1 at 16 ticks per bit -> one O_rx_valid with O_rx_data=0xA5 and O_rx_frame_err=0; O_rx_busy is high for the frame.
REQ-028 Hold I_rx low for 3 ticks, then high -> no O_rx_valid, and the block is back in IDLE before tick 8.
REQ-029 Send 0x3C with the stop bit low, then hold the line low for 40 ticks -> O_rx_valid and O_rx_frame_err pulse together with data 0x3C, and no second frame until the line goes high.
REQ-030 Send 0x00 then 0xFF back-to-back with no gap -> two O_rx_valid pulses with data 0x00 then 0xFF, and no error.
REQ-031 With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> O_rx_parity_err=1; send 0x01 with parity bit 1 -> O_rx_parity_err=0.
REQ-032 Assert rst_n=0 during bit 4 of a frame, then release -> all outputs at reset values, no pulse, and the next frame 0x5A is received correctly.
